// File: rtl/bird_sprite_fetch.sv
// bird_sprite_fetch
//   Read side of the bird sprite ROM. Turns the VGA scan position plus the
//   bird position into ROM addresses, realigns the returned pixel with the
//   scan stream and applies colour-key transparency. Wing-flap frames are
//   stored back-to-back in the ROM and stepped every FLAP_DIV video frames.
//
//   Optional feature macro: BIRD_SPRITE_HFLIP_EN adds the hflip input
//   (latched on frame_start) that mirrors the sprite horizontally.
//
// Ports
//   clka, rsta_n          pixel clock, async active-low reset
//   frame_start           one-cycle pulse at the start of each video frame
//   pix_de, pix_x, pix_y  scan slot (cycle N)
//   bird_x, bird_y        sprite top-left, latched on frame_start
//   hflip                 (BIRD_SPRITE_HFLIP_EN only) mirror, latched on frame_start
//   rom_addr              registered ROM address (edge N+1)
//   rom_data              ROM read data, valid during cycle N+2
//   spr_rgb, spr_vld      sprite pixel and opaque/in-box flag (edge N+3)
//   anim_frame            current animation frame index
module bird_sprite_fetch #(
  parameter int          SPR_W    = 45,
  parameter int          SPR_H    = 45,
  parameter int          FRAMES   = 1,
  parameter int          FLAP_DIV = 8,
  parameter int          ADDR_W   = 11,
  parameter logic [15:0] KEY_RGB  = 16'hF81F
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              frame_start,
  input  logic              pix_de,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [9:0]        bird_x,
  input  logic [9:0]        bird_y,
`ifdef BIRD_SPRITE_HFLIP_EN
  input  logic              hflip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       spr_rgb,
  output logic              spr_vld,
  output logic [7:0]        anim_frame
);

  localparam int CW = (FLAP_DIV > 1) ? $clog2(FLAP_DIV) : 1;

  logic [9:0]        pos_x, pos_y;
  logic [CW-1:0]     flap_cnt, flap_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [7:0]        frame_nxt;
  logic [2:1]        vld_pipe;

  // effective (same-cycle) values: on frame_start the new position/base
  // already apply to the stage-0 pixel
  logic [9:0]        px, py, dx, dy, col;
  logic              in_box, flip_eff;
  logic [ADDR_W-1:0] addr_nxt;

`ifdef BIRD_SPRITE_HFLIP_EN
  logic flip_q;
  assign flip_eff = frame_start ? hflip : flip_q;
`else
  assign flip_eff = 1'b0;
`endif

  // animation step; base tracks anim_frame*SPR_W*SPR_H without a multiplier
  always_comb begin
    flap_nxt  = flap_cnt;
    frame_nxt = anim_frame;
    base_nxt  = base;
    if (frame_start) begin
      if (flap_cnt == CW'(FLAP_DIV-1)) begin
        flap_nxt = '0;
        if (anim_frame == 8'(FRAMES-1)) begin
          frame_nxt = '0;
          base_nxt  = '0;
        end else begin
          frame_nxt = anim_frame + 8'd1;
          base_nxt  = base + ADDR_W'(SPR_W*SPR_H);
        end
      end else begin
        flap_nxt = flap_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      pos_x      <= '0;
      pos_y      <= '0;
      flap_cnt   <= '0;
      anim_frame <= '0;
      base       <= '0;
    end else if (frame_start) begin
      pos_x      <= bird_x;
      pos_y      <= bird_y;
      flap_cnt   <= flap_nxt;
      anim_frame <= frame_nxt;
      base       <= base_nxt;
    end
  end

`ifdef BIRD_SPRITE_HFLIP_EN
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n)          flip_q <= 1'b0;
    else if (frame_start) flip_q <= hflip;
  end
`endif

  // stage 0: box test in 11 bits so a box past column/row 1023 never wraps
  always_comb begin
    px     = frame_start ? bird_x : pos_x;
    py     = frame_start ? bird_y : pos_y;
    dx     = pix_x - px;
    dy     = pix_y - py;
    in_box = pix_de &
             ({1'b0, pix_x} >= {1'b0, px}) & ({1'b0, pix_x} < {1'b0, px} + 11'(SPR_W)) &
             ({1'b0, pix_y} >= {1'b0, py}) & ({1'b0, pix_y} < {1'b0, py} + 11'(SPR_H));
    col      = flip_eff ? (10'(SPR_W-1) - dx) : dx;
    addr_nxt = base_nxt + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  // stage 1..3: address, ROM latency slot, output
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rom_addr <= '0;
      vld_pipe <= '0;
      spr_rgb  <= '0;
      spr_vld  <= 1'b0;
    end else begin
      if (in_box) rom_addr <= addr_nxt;
      vld_pipe <= {vld_pipe[1], in_box};
      spr_rgb  <= vld_pipe[2] ? rom_data : 16'h0000;
      spr_vld  <= vld_pipe[2] & (rom_data != KEY_RGB);
    end
  end

endmodule

// File: tb/tb_bird_sprite_fetch.sv
module tb_bird_sprite_fetch;
  localparam int AW = 13;

  logic          clka = 1'b0;
  logic          rsta_n, frame_start, pix_de, hflip;
  logic [9:0]    pix_x, pix_y, bird_x, bird_y;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic [15:0]   spr_rgb;
  logic          spr_vld;
  logic [7:0]    anim_frame;

  int ntests = 0;
  int nfail  = 0;

  always #5 clka = ~clka;

  bird_sprite_fetch #(.SPR_W(45), .SPR_H(45), .FRAMES(3), .FLAP_DIV(2),
                      .ADDR_W(AW), .KEY_RGB(16'hF81F)) dut (
    .clka(clka), .rsta_n(rsta_n), .frame_start(frame_start),
    .pix_de(pix_de), .pix_x(pix_x), .pix_y(pix_y),
    .bird_x(bird_x), .bird_y(bird_y),
`ifdef BIRD_SPRITE_HFLIP_EN
    .hflip(hflip),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data),
    .spr_rgb(spr_rgb), .spr_vld(spr_vld), .anim_frame(anim_frame));

  // ROM contents: addr 5 holds the colour key, addr 1 pure green, else addr^1234
  function automatic logic [15:0] rom_fn(input logic [AW-1:0] a);
    if (a == 5)      return 16'hF81F;
    else if (a == 1) return 16'h07E0;
    else             return 16'(a) ^ 16'h1234;
  endfunction

  always @(posedge clka) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic de, input logic fs);
    pix_x = 10'(x); pix_y = 10'(y); pix_de = de; frame_start = fs;
  endtask

  task automatic step;
    @(posedge clka); @(negedge clka);
  endtask

  task automatic pulse(input int bx, input int by);
    bird_x = 10'(bx); bird_y = 10'(by);
    drive(0, 0, 1'b0, 1'b1); step; frame_start = 1'b0;
  endtask

  typedef struct {
    int          x, y;
    logic        de;
    int          addr;
    logic        vld;
    logic [15:0] rgb;
  } vec_t;

  localparam int N = 12;
  vec_t tbl[N];
  int   anim_exp[6];

  initial begin
    // pos (100,50), base 0
    tbl[0]  = '{100, 50, 1'b1,    0, 1'b1, 16'h1234};
    tbl[1]  = '{101, 50, 1'b1,    1, 1'b1, 16'h07E0};
    tbl[2]  = '{105, 50, 1'b1,    5, 1'b0, 16'hF81F};
    tbl[3]  = '{ 99, 50, 1'b1,    5, 1'b0, 16'h0000};
    tbl[4]  = '{145, 50, 1'b1,    5, 1'b0, 16'h0000};
    tbl[5]  = '{144, 94, 1'b1, 2024, 1'b1, 16'h15DC};
    tbl[6]  = '{144, 95, 1'b1, 2024, 1'b0, 16'h0000};
    tbl[7]  = '{120, 60, 1'b0, 2024, 1'b0, 16'h0000};
    tbl[8]  = '{110, 52, 1'b1,  100, 1'b1, 16'h1250};
    tbl[9]  = '{100, 49, 1'b1,  100, 1'b0, 16'h0000};
    tbl[10] = '{144, 50, 1'b1,   44, 1'b1, 16'h1218};
    tbl[11] = '{100, 94, 1'b1, 1980, 1'b1, 16'h1588};
    anim_exp = '{0, 1, 1, 2, 2, 0};

    rsta_n = 1'b0; hflip = 1'b0; bird_x = '0; bird_y = '0;
    drive(0, 0, 1'b0, 1'b0);
    repeat (2) step;
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_rgb",  32'(spr_rgb), 0);
    chk("rst_vld",  32'(spr_vld), 0);
    chk("rst_anim", 32'(anim_frame), 0);
    rsta_n = 1'b1;
    step;

    pulse(100, 50);
    chk("anim_p1", 32'(anim_frame), 0);

    // streamed table: addr at +1, sprite output at +3
    for (int m = 0; m < N + 2; m++) begin
      if (m < N) drive(tbl[m].x, tbl[m].y, tbl[m].de, 1'b0);
      else       drive(0, 0, 1'b0, 1'b0);
      step;
      if (m < N) chk($sformatf("addr[%0d]", m), 32'(rom_addr), 32'(tbl[m].addr));
      if (m >= 2) begin
        chk($sformatf("vld[%0d]", m-2), 32'(spr_vld), 32'(tbl[m-2].vld));
        chk($sformatf("rgb[%0d]", m-2), 32'(spr_rgb), 32'(tbl[m-2].rgb));
      end
    end

    // reset mid-stream
    drive(110, 52, 1'b1, 1'b0);
    repeat (3) step;
    chk("pre_rst_vld",  32'(spr_vld), 1);
    chk("pre_rst_addr", 32'(rom_addr), 100);
    @(posedge clka); #2 rsta_n = 1'b0; #1;
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_rgb",  32'(spr_rgb), 0);
    chk("mid_rst_vld",  32'(spr_vld), 0);
    @(negedge clka);
    rsta_n = 1'b1;
    drive(0, 0, 1'b1, 1'b0);   // pos is back to (0,0): in box
    step; chk("lat_vld_p1", 32'(spr_vld), 0);
    step; chk("lat_vld_p2", 32'(spr_vld), 0);
    step; chk("lat_vld_p3", 32'(spr_vld), 1);
    chk("lat_rgb_p3", 32'(spr_rgb), 32'h1234);

    // animation: FRAMES=3, FLAP_DIV=2
    for (int k = 0; k < 6; k++) begin
      pulse(0, 0);
      chk($sformatf("anim[%0d]", k), 32'(anim_frame), 32'(anim_exp[k]));
      step;
    end
    pulse(0, 0);
    chk("anim_p7", 32'(anim_frame), 0);
    // pulse coincident with first pixel: new base used at once
    bird_x = 10'd0; bird_y = 10'd0;
    drive(0, 0, 1'b1, 1'b1); step; frame_start = 1'b0;
    chk("anim_p8", 32'(anim_frame), 1);
    chk("f1_addr", 32'(rom_addr), 2025);

    // mid-frame bird change ignored until next frame_start
    pulse(100, 50);
    chk("anim_p9", 32'(anim_frame), 1);
    bird_x = 10'd200;
    drive(100, 50, 1'b1, 1'b0); step; chk("tear_a", 32'(rom_addr), 2025);
    drive(101, 50, 1'b1, 1'b0); step; chk("tear_b", 32'(rom_addr), 2026);
    drive(200, 50, 1'b1, 1'b0); step; chk("tear_c", 32'(rom_addr), 2026);

    // box at the right edge never wraps to low columns
    pulse(1000, 50);
    chk("anim_p10", 32'(anim_frame), 2);
    drive(1000, 50, 1'b1, 1'b0); step; chk("edge_a", 32'(rom_addr), 4050);
    drive(1023, 50, 1'b1, 1'b0); step; chk("edge_b", 32'(rom_addr), 4073);
    for (int c = 0; c <= 20; c++) begin
      drive(c, 50, 1'b1, 1'b0); step;
      chk($sformatf("nowrap_addr[%0d]", c), 32'(rom_addr), 4073);
      if (c >= 2) chk($sformatf("nowrap_vld[%0d]", c-2), 32'(spr_vld), 0);
    end

`ifdef BIRD_SPRITE_HFLIP_EN
    hflip = 1'b1;
    pulse(100, 50);
    hflip = 1'b0;   // latched value must persist
    drive(100, 50, 1'b1, 1'b0); step; chk("hflip_a", 32'(rom_addr), 4050 + 44);
    drive(144, 50, 1'b1, 1'b0); step; chk("hflip_b", 32'(rom_addr), 4050);
`endif

    drive(0, 0, 1'b0, 1'b0);
    step;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
